index_onehot_decoder: RTL and testbench

- Converts the 3-bit index produced by the 8x3 priority encoder back into an 8-bit one-hot vector.
- Sits at the consumer end of the encoder link and carries a valid/ready handshake.
- Registered output stage with a 2-entry skid buffer, so back-pressure never drops or duplicates a code.
- Carries a "none" flag for the all-zero encoder input case, which decodes to 8'h00.

---
 rtl/index_codec_pkg.sv | 21 ++
 rtl/index_onehot_decoder_skid_buffer2.sv | 79 +++++++
 rtl/index_onehot_decoder.sv | 98 +++++++++
 tb/tb_index_onehot_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/index_codec_pkg.sv
// Shared definitions for the index/one-hot codec link: widths, the decoded
// entry carried through the output buffer, and the buffer occupancy states.
package index_codec_pkg;

   localparam int IDX_W = 3;
   localparam int OUT_W = 8;

   // One decoded word as it sits in the buffer.
   typedef struct packed {
      logic             none;
      logic [OUT_W-1:0] onehot;
   } entry_t;

   // Buffer occupancy: nothing held, head only, head plus skid.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_t;

endpackage

// File: rtl/index_onehot_decoder_skid_buffer2.sv
// skid_buffer2: generic 2-entry valid/ready buffer. The head entry drives the
// outputs directly from registers; the skid entry absorbs one extra word so
// in_ready depends only on registered occupancy, never on out_ready.
module skid_buffer2
   import index_codec_pkg::*;
#(
   parameter int W = 9
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   buf_state_t   state_reg, state_next;
   logic [W-1:0] head_reg, head_next;
   logic [W-1:0] skid_reg, skid_next;
   logic         accept;
   logic         drain;

   assign in_ready  = (state_reg != FULL);
   assign out_valid = (state_reg != EMPTY);
   assign out_data  = head_reg;
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   // Occupancy and entry registers; reset discards both entries at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
         head_reg  <= '0;
         skid_reg  <= '0;
      end else begin
         state_reg <= state_next;
         head_reg  <= head_next;
         skid_reg  <= skid_next;
      end
   end

   // Next occupancy and entry movement for each accept/drain combination.
   always_comb begin
      state_next = state_reg;
      head_next  = head_reg;
      skid_next  = skid_reg;
      case (state_reg)
         EMPTY: begin
            if (accept) begin
               state_next = ONE;
               head_next  = in_data;
            end
         end
         ONE: begin
            if (accept && drain) begin
               // Replace the head in place: full throughput, no bubble.
               head_next = in_data;
            end else if (accept) begin
               state_next = FULL;
               skid_next  = in_data;
            end else if (drain) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (drain) begin
               state_next = ONE;
               head_next  = skid_reg;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

endmodule

// File: rtl/index_onehot_decoder.sv
// index_onehot_decoder: turns a priority-encoder index (plus its "none" flag)
// back into a one-hot word, buffered through a 2-entry skid buffer.
// Optional feature macro: INDEX_DECODER_CNT_EN adds saturating transfer
// counters xfer_cnt (normal words) and none_cnt (none words).
module index_onehot_decoder
   import index_codec_pkg::*;
#(
   parameter int IDX_W = index_codec_pkg::IDX_W,
   parameter int OUT_W = index_codec_pkg::OUT_W
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_idx,
   input  logic             in_none,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_onehot,
   output logic             out_none
`ifdef INDEX_DECODER_CNT_EN
   ,
   output logic [15:0]      xfer_cnt,
   output logic [15:0]      none_cnt
`endif
);

   localparam int ENTRY_W = $bits(entry_t);

   // The one-hot width must cover every index exactly and match the entry type.
   generate
      if ((OUT_W != (2 ** IDX_W)) || (OUT_W != index_codec_pkg::OUT_W)) begin : g_bad_width
         $error("index_onehot_decoder: OUT_W must equal 2**IDX_W and the package OUT_W");
      end
   endgenerate

   logic [OUT_W-1:0] dec_onehot;
   entry_t           dec_entry;
   entry_t           head_entry;

   // Decode at capture time: each bit fires when the index selects it and
   // the encoder reported an active input.
   generate
      for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
         assign dec_onehot[gi] = !in_none && (in_idx == IDX_W'(gi));
      end
   endgenerate

   // Pack the decoded word into a buffer entry.
   always_comb begin
      dec_entry        = '0;
      dec_entry.none   = in_none;
      dec_entry.onehot = dec_onehot;
   end

   skid_buffer2 #(
      .W (ENTRY_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (dec_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head_entry)
   );

   assign out_onehot = head_entry.onehot;
   assign out_none   = head_entry.none;

`ifdef INDEX_DECODER_CNT_EN
   logic        out_fire;
   logic [15:0] xfer_cnt_reg;
   logic [15:0] none_cnt_reg;

   assign out_fire = out_valid & out_ready;

   // Saturating counts of delivered words, split by the none flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt_reg <= '0;
         none_cnt_reg <= '0;
      end else if (out_fire) begin
         if (!out_none && (xfer_cnt_reg != 16'hFFFF)) begin
            xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
         end
         if (out_none && (none_cnt_reg != 16'hFFFF)) begin
            none_cnt_reg <= none_cnt_reg + 16'd1;
         end
      end
   end

   assign xfer_cnt = xfer_cnt_reg;
   assign none_cnt = none_cnt_reg;
`endif

endmodule

// File: tb/tb_index_onehot_decoder.sv
// Bench for index_onehot_decoder: directed cases with literal expectations,
// then random traffic compared every cycle against a queue model.
module tb_index_onehot_decoder;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_idx;
   logic       in_none;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_onehot;
   logic       out_none;
`ifdef INDEX_DECODER_CNT_EN
   logic [15:0] xfer_cnt;
   logic [15:0] none_cnt;
`endif

   index_onehot_decoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_idx     (in_idx),
      .in_none    (in_none),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .out_none   (out_none)
`ifdef INDEX_DECODER_CNT_EN
      ,
      .xfer_cnt   (xfer_cnt),
      .none_cnt   (none_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;
   bit quiet  = 1'b0;

   // Model: FIFO of expected {none, onehot} words, capacity two.
   logic [8:0]  mq[$];
   logic [15:0] m_xfer = 16'd0;
   logic [15:0] m_none = 16'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model update at each edge, using the occupancy before the edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_xfer = 16'd0;
         m_none = 16'd0;
      end else begin
         int  pre;
         bit  acc;
         bit  drn;
         logic [8:0] w;
         pre = mq.size();
         acc = in_valid && (pre < 2);
         drn = (pre > 0) && out_ready;
         if (drn) begin
            w = mq.pop_front();
            if (!quiet) $display("[TB] out word onehot=%02h none=%0b", w[7:0], w[8]);
            if (w[8]) begin
               if (m_none != 16'hFFFF) m_none = m_none + 16'd1;
            end else begin
               if (m_xfer != 16'hFFFF) m_xfer = m_xfer + 16'd1;
            end
         end
         if (acc) begin
            if (in_none) mq.push_back(9'h100);
            else         mq.push_back({1'b0, 8'h01 << in_idx});
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, (mq.size() < 2)});
         chk("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
         if (mq.size() > 0) begin
            chk("out_onehot", {24'd0, out_onehot}, {24'd0, mq[0][7:0]});
            chk("out_none", {31'd0, out_none}, {31'd0, mq[0][8]});
         end
`ifdef INDEX_DECODER_CNT_EN
         chk("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, m_xfer});
         chk("none_cnt", {16'd0, none_cnt}, {16'd0, m_none});
`endif
      end
   end

   logic [7:0] sweep_exp [9];

   initial begin
      sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_idx    = 3'd0;
      in_none   = 1'b0;
      out_ready = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst out_onehot", {24'd0, out_onehot}, 32'h00);
      chk("rst out_none", {31'd0, out_none}, 32'd0);
      chk("rst in_ready", {31'd0, in_ready}, 32'd1);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // First word: idx 5 appears the next cycle
      in_valid = 1'b1; in_idx = 3'd5; out_ready = 1'b1;
      step();
      chk("first onehot", {24'd0, out_onehot}, 32'h20);
      chk("first valid", {31'd0, out_valid}, 32'd1);

      // Full sweep, one word per cycle
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_idx   = 3'(i);
         in_none  = (i == 8);
         step();
         chk("sweep onehot", {24'd0, out_onehot}, {24'd0, sweep_exp[i]});
         chk("sweep none", {31'd0, out_none}, {31'd0, (i == 8)});
         chk("sweep valid", {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0; in_none = 1'b0;
      step();
      chk("sweep drained", {31'd0, out_valid}, 32'd0);

      // Back-pressure: 3, 6 accepted, 1 held upstream
      out_ready = 1'b0;
      in_valid = 1'b1; in_idx = 3'd3;
      step();
      chk("bp ready1", {31'd0, in_ready}, 32'd1);
      chk("bp head", {24'd0, out_onehot}, 32'h08);
      in_idx = 3'd6;
      step();
      chk("bp ready2", {31'd0, in_ready}, 32'd0);
      in_idx = 3'd1;
      step();
      chk("bp held", {31'd0, in_ready}, 32'd0);
      chk("bp head2", {24'd0, out_onehot}, 32'h08);
      out_ready = 1'b1;
      step();
      chk("bp out2", {24'd0, out_onehot}, 32'h40);
      chk("bp ready3", {31'd0, in_ready}, 32'd1);
      step();
      chk("bp out3", {24'd0, out_onehot}, 32'h02);
      in_valid = 1'b0;
      step();
      chk("bp drained", {31'd0, out_valid}, 32'd0);

      // Stability under stall
      out_ready = 1'b0;
      in_valid = 1'b1; in_idx = 3'd4;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall onehot", {24'd0, out_onehot}, 32'h10);
         chk("stall valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      step();
      chk("stall drained", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset while FULL
      out_ready = 1'b0;
      in_valid = 1'b1; in_idx = 3'd2;
      step();
      in_idx = 3'd7;
      step();
      in_valid = 1'b0;
      chk("full ready", {31'd0, in_ready}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst valid", {31'd0, out_valid}, 32'd0);
      chk("arst onehot", {24'd0, out_onehot}, 32'h00);
      chk("arst none", {31'd0, out_none}, 32'd0);
      chk("arst ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post arst valid", {31'd0, out_valid}, 32'd0);
      end

      // Randomized traffic, checked by the compare process
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 99) < 70);
         in_idx    = 3'($urandom_range(0, 7));
         in_none   = ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 99) < 60);
         step();
      end
      in_valid = 1'b0; in_none = 1'b0; out_ready = 1'b1;
      repeat (3) step();

`ifdef INDEX_DECODER_CNT_EN
      // Counters: 3 normal, 2 none
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_idx   = 3'(i);
         in_none  = (i >= 3);
         step();
      end
      in_valid = 1'b0; in_none = 1'b0;
      repeat (2) step();
      chk("cnt xfer 3", {16'd0, xfer_cnt}, 32'd3);
      chk("cnt none 2", {16'd0, none_cnt}, 32'd2);
      quiet = 1'b1;
      in_valid = 1'b1; in_idx = 3'd0;
      repeat (70000) step();
      in_valid = 1'b0;
      repeat (2) step();
      quiet = 1'b0;
      chk("cnt xfer sat", {16'd0, xfer_cnt}, 32'h0000FFFF);
      chk("cnt none kept", {16'd0, none_cnt}, 32'd2);
`endif

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
